control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock shared with the datapath.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port InstrControl, input, 20 bits: instruction bits [31:12], laid out as follows.
  - [19:16] Cond
  - [15:14] Op
  - [13:8] Funct, which is Instr[25:20]: I=[13], cmd=[12:9], S=[8]
  - [7:4] Rd
REQ-004 The block SHALL have port ALUFlags, input, 4 bits: {N,Z,C,V} from the ALU for the current instruction.
REQ-005 The block SHALL have port Control, output, 13 bits, laid out as follows.
  - [12] PCSrc
  - [11] MemtoReg
  - [10] MemWrite
  - [9:6] ALUControl
  - [5] ALUSrc
  - [4:3] ImmSrc
  - [2] RegWrite
  - [1:0] RegSrc
REQ-006 The block SHALL have port Flags, output, 4 bits: registered {N,Z,C,V}.
REQ-007 The block SHALL have port Illegal, output, 1 bit: high while an unsupported encoding is decoded in RUN.
REQ-008 The block SHALL have port InstrCount, output, 32 bits: count of executed instructions.

Function
REQ-009 The block SHALL implement a two-state FSM with states WAIT and RUN.
  - rst forces WAIT.
  - WAIT->RUN after exactly one cycle.
  - RUN holds until rst.
REQ-010 In WAIT, Control SHALL be 13'b0, Illegal SHALL be 0, and InstrCount and Flags SHALL hold; this covers the registered instruction-memory read latency.
REQ-011 Control SHALL be combinational from InstrControl, the registered Flags and the FSM state, with zero-cycle latency.
REQ-012 ALUControl encoding SHALL be: ADD 0000, SUB 0001, AND 0010, ORR 0011, EOR 0100, MOV 0101 (pass SrcB).
REQ-013 Op=00 (data processing) SHALL set ImmSrc=00, ALUSrc=I, RegSrc=00, MemtoReg=0, RegWrite=1, except CMP.
  - cmd mapping: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV.
  - CMP (1010) SHALL drive SUB with RegWrite=0; its S bit is treated as 1.
REQ-014 Op=01 (memory) SHALL set ImmSrc=01, ALUSrc=1, and ALUControl = ADD when U (Funct[3])=1, SUB otherwise.
  - Load (L=Funct[0]=1): MemtoReg=1, RegWrite=1, RegSrc=00.
  - Store: MemWrite=1, RegWrite=0, RegSrc=10.
REQ-015 Op=10 (branch) SHALL set ImmSrc=10, ALUSrc=1, ALUControl=ADD, RegSrc=01, PCSrc=1, RegWrite=0.
REQ-016 Op=11, or an unlisted data-processing cmd, SHALL drive Control=0 and Illegal=1, with no flag update and no count.
REQ-017 PCSrc SHALL additionally assert when Rd=1111 and the unconditioned RegWrite=1.
REQ-018 Condition evaluation against the registered Flags SHALL be as follows.
  - EQ 0000, NE 0001, CS 0010, CC 0011, MI 0100, PL 0101, VS 0110, VC 0111, HI 1000, LS 1001, GE 1010, LT 1011, GT 1100, LE 1101, AL 1110.
  - 1111 SHALL be treated as never-execute.
REQ-019 Each of PCSrc, RegWrite and MemWrite SHALL be ANDed with CondEx and with (state==RUN); all other Control fields SHALL be unaffected by CondEx.
REQ-020 Flags SHALL update at the clock edge only when all of the following hold: RUN, Op=00, S=1, CondEx=1, and not illegal.
  - N and Z SHALL always load.
  - C and V SHALL load only for ADD, SUB and CMP; otherwise they hold.
REQ-021 An instruction SHALL see the Flags written by the immediately preceding instruction, with no forwarding of ALUFlags into the condition check.
REQ-022 InstrCount SHALL increment by 1 at each edge in RUN when CondEx=1 and not illegal, wrapping from 0xFFFFFFFF to 0.
REQ-023 Simultaneous rst and any update SHALL resolve in favour of rst.

Reset
REQ-024 On rst the block SHALL set state=WAIT, Flags=4'b0000 and InstrCount=0, and Control and Illegal SHALL read 0 during the reset cycle and the following WAIT cycle.
REQ-025 A rst asserted mid-RUN SHALL discard any pending flag or count update in that cycle.

Verification
REQ-026 Reset then ADDS (Cond=1110, Op=00, Funct=001001) with ALUFlags=0100 SHALL give Control=0 in the WAIT cycle, then RegWrite=1 and ALUControl=0000, and Flags=0100 after the next edge.
REQ-027 CMP setting Z, followed by BEQ then BNE, SHALL give PCSrc=1 for BEQ and PCSrc=0 for BNE, with InstrCount incremented only for CMP and BEQ.
REQ-028 STR with U=0 SHALL give MemWrite=1, ALUControl=0001, ImmSrc=01, ALUSrc=1, RegSrc=10, RegWrite=0; the same STR with Cond=0000 and Z=0 SHALL give MemWrite=0.
REQ-029 LDR with Rd=1111 SHALL give MemtoReg=1, RegWrite=1, PCSrc=1.
REQ-030 Op=11 SHALL give Control=0 and Illegal=1 with Flags and InstrCount unchanged; preloading InstrCount to 0xFFFFFFFF and executing an AL instruction SHALL give 0.
REQ-031 ANDS with C=1 in Flags and ALUFlags=1000 SHALL give Flags=1010.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: ARM-subset instruction decoder with condition check, flag register and instruction counter.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] InstrControl,
  input  logic [3:0]  ALUFlags,
  output logic [12:0] Control,
  output logic [3:0]  Flags,
  output logic        Illegal,
  output logic [31:0] InstrCount
);
  typedef enum logic {S_WAIT, S_RUN} state_t;
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND = 4'b0010,
                         ORR = 4'b0011, EOR = 4'b0100, MOV = 4'b0101;
  state_t      r_state;
  logic [3:0]  r_flags;
  logic [31:0] r_count;
  logic [3:0]  w_cond, w_cmd, w_rd, w_dp_alu, w_alu;
  logic [1:0]  w_op, w_regsrc;
  logic        w_i, w_s, w_u, w_l, w_dp_ok, w_cv, w_cmp, w_bad, w_run, w_condex;
  logic        w_n, w_z, w_c, w_v, w_memtoreg, w_memw, w_regw, w_pcs, w_alusrc;
  logic        w_fupd, w_cnt, w_unused;
  assign w_cond = InstrControl[19:16];
  assign w_op   = InstrControl[15:14];
  assign w_i    = InstrControl[13];
  assign w_cmd  = InstrControl[12:9];
  assign w_s    = InstrControl[8];
  assign w_rd   = InstrControl[7:4];
  assign w_u    = InstrControl[11];
  assign w_l    = InstrControl[8];
  assign w_unused = &{1'b0, InstrControl[3:0]};
  assign {w_n, w_z, w_c, w_v} = r_flags;
  always_comb begin
    w_dp_alu = ADD;
    w_dp_ok = 1'b1;
    w_cv = 1'b0;
    case (w_cmd)
      4'b0100: begin w_dp_alu = ADD; w_cv = 1'b1; end
      4'b0010, 4'b1010: begin w_dp_alu = SUB; w_cv = 1'b1; end
      4'b0000: w_dp_alu = AND;
      4'b1100: w_dp_alu = ORR;
      4'b0001: w_dp_alu = EOR;
      4'b1101: w_dp_alu = MOV;
      default: w_dp_ok = 1'b0;
    endcase
  end
  always_comb begin
    w_condex = 1'b0;
    case (w_cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = ~w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = ~w_v;
      4'b1000: w_condex = w_c & ~w_z;
      4'b1001: w_condex = ~w_c | w_z;
      4'b1010: w_condex = w_n == w_v;
      4'b1011: w_condex = w_n != w_v;
      4'b1100: w_condex = ~w_z & (w_n == w_v);
      4'b1101: w_condex = w_z | (w_n != w_v);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end
  assign w_cmp      = w_cmd == 4'b1010;
  assign w_bad      = (w_op == 2'b11) | ((w_op == 2'b00) & ~w_dp_ok);
  assign w_run      = (r_state == S_RUN) & ~rst;
  assign w_memtoreg = (w_op == 2'b01) & w_l;
  assign w_memw     = (w_op == 2'b01) & ~w_l;
  assign w_alu      = w_op == 2'b00 ? w_dp_alu : w_op == 2'b01 ? (w_u ? ADD : SUB) : ADD;
  assign w_alusrc   = w_op == 2'b00 ? w_i : 1'b1;
  assign w_regw     = w_op == 2'b00 ? ~w_cmp : w_op == 2'b01 ? w_l : 1'b0;
  assign w_regsrc   = w_memw ? 2'b10 : w_op == 2'b10 ? 2'b01 : 2'b00;
  assign w_pcs      = (w_op == 2'b10) | ((w_rd == 4'b1111) & w_regw);
  // ImmSrc equals Op for every legal opcode
  assign Control = (~w_run | w_bad) ? 13'b0 :
                   {w_pcs & w_condex, w_memtoreg, w_memw & w_condex, w_alu, w_alusrc,
                    w_op, w_regw & w_condex, w_regsrc};
  assign Illegal    = w_run & w_bad;
  assign w_cnt      = w_run & w_condex & ~w_bad;
  assign w_fupd     = w_cnt & (w_op == 2'b00) & (w_s | w_cmp);
  assign Flags      = r_flags;
  assign InstrCount = r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_flags <= 4'b0;
      r_count <= 32'b0;
    end else begin
      r_state <= S_RUN;
      if (w_fupd) r_flags <= {ALUFlags[3:2], w_cv ? ALUFlags[1:0] : r_flags[1:0]};
      if (w_cnt) r_count <= r_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vector table plus reset and counter-wrap sequences for control_unit.
module tb_control_unit;
  logic        clk, rst;
  logic [19:0] InstrControl;
  logic [3:0]  ALUFlags;
  logic [12:0] Control;
  logic [3:0]  Flags;
  logic        Illegal;
  logic [31:0] InstrCount;
  int n_tests = 0, n_fail = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .InstrControl(InstrControl), .ALUFlags(ALUFlags),
    .Control(Control), .Flags(Flags), .Illegal(Illegal), .InstrCount(InstrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] ins;
    logic [3:0]  af;
    logic [12:0] ctrl;
    logic        ill;
    logic [3:0]  fl;
    logic [31:0] cnt;
  } vec_t;
  vec_t v[17];

  function automatic logic [19:0] ins(input logic [3:0] cond, input logic [1:0] op,
                                      input logic [5:0] funct, input logic [3:0] rd);
    return {cond, op, funct, rd, 4'b0000};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    v[0]  = '{ins(4'hE, 2'b00, 6'b001001, 4'd1),  4'b0100, 13'h0004, 1'b0, 4'b0100, 32'd1};
    v[1]  = '{ins(4'hE, 2'b00, 6'b010100, 4'd0),  4'b0110, 13'h0040, 1'b0, 4'b0110, 32'd2};
    v[2]  = '{ins(4'h0, 2'b10, 6'b000000, 4'd0),  4'b1111, 13'h1031, 1'b0, 4'b0110, 32'd3};
    v[3]  = '{ins(4'h1, 2'b10, 6'b000000, 4'd0),  4'b1111, 13'h0031, 1'b0, 4'b0110, 32'd3};
    v[4]  = '{ins(4'hE, 2'b00, 6'b000001, 4'd2),  4'b1000, 13'h0084, 1'b0, 4'b1010, 32'd4};
    v[5]  = '{ins(4'hE, 2'b01, 6'b010000, 4'd3),  4'b0000, 13'h046A, 1'b0, 4'b1010, 32'd5};
    v[6]  = '{ins(4'h0, 2'b01, 6'b010000, 4'd3),  4'b0000, 13'h006A, 1'b0, 4'b1010, 32'd5};
    v[7]  = '{ins(4'hE, 2'b01, 6'b011001, 4'd15), 4'b0000, 13'h182C, 1'b0, 4'b1010, 32'd6};
    v[8]  = '{ins(4'hE, 2'b11, 6'b000000, 4'd0),  4'b0100, 13'h0000, 1'b1, 4'b1010, 32'd6};
    v[9]  = '{ins(4'hE, 2'b00, 6'b000111, 4'd1),  4'b0100, 13'h0000, 1'b1, 4'b1010, 32'd6};
    v[10] = '{ins(4'hA, 2'b00, 6'b001001, 4'd1),  4'b0101, 13'h0000, 1'b0, 4'b1010, 32'd6};
    v[11] = '{ins(4'hB, 2'b00, 6'b001001, 4'd1),  4'b0101, 13'h0004, 1'b0, 4'b0101, 32'd7};
    v[12] = '{ins(4'hE, 2'b00, 6'b111010, 4'd15), 4'b1111, 13'h1164, 1'b0, 4'b0101, 32'd8};
    v[13] = '{ins(4'hF, 2'b00, 6'b001001, 4'd1),  4'b0000, 13'h0000, 1'b0, 4'b0101, 32'd8};
    v[14] = '{ins(4'h6, 2'b00, 6'b000011, 4'd1),  4'b1000, 13'h0104, 1'b0, 4'b1001, 32'd9};
    v[15] = '{ins(4'h8, 2'b00, 6'b000101, 4'd1),  4'b0100, 13'h0040, 1'b0, 4'b1001, 32'd9};
    v[16] = '{ins(4'h9, 2'b00, 6'b101000, 4'd1),  4'b0100, 13'h0024, 1'b0, 4'b1001, 32'd10};

    rst = 1'b1;
    InstrControl = v[0].ins;
    ALUFlags = 4'b0100;
    @(negedge clk);
    check("reset_ctrl", 32'(Control), 32'd0);
    check("reset_illegal", 32'(Illegal), 32'd0);
    @(posedge clk); #1;
    check("reset_flags", 32'(Flags), 32'd0);
    check("reset_count", InstrCount, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("wait_ctrl", 32'(Control), 32'd0);
    check("wait_illegal", 32'(Illegal), 32'd0);
    @(posedge clk); #1;
    check("wait_flags_hold", 32'(Flags), 32'd0);
    check("wait_count_hold", InstrCount, 32'd0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      InstrControl = v[i].ins;
      ALUFlags = v[i].af;
      #1;
      check($sformatf("v%0d_ctrl", i), 32'(Control), 32'(v[i].ctrl));
      check($sformatf("v%0d_illegal", i), 32'(Illegal), 32'(v[i].ill));
      @(posedge clk); #1;
      check($sformatf("v%0d_flags", i), 32'(Flags), 32'(v[i].fl));
      check($sformatf("v%0d_count", i), InstrCount, v[i].cnt);
    end

    @(negedge clk);
    rst = 1'b1;
    InstrControl = ins(4'hE, 2'b00, 6'b001001, 4'd1);
    ALUFlags = 4'b1111;
    #1;
    check("midrst_ctrl", 32'(Control), 32'd0);
    check("midrst_illegal", 32'(Illegal), 32'd0);
    @(posedge clk); #1;
    check("midrst_flags", 32'(Flags), 32'd0);
    check("midrst_count", InstrCount, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_wait_ctrl", 32'(Control), 32'd0);
    @(posedge clk); #1;
    check("midrst_wait_flags", 32'(Flags), 32'd0);
    check("midrst_wait_count", InstrCount, 32'd0);

    @(negedge clk);
    force dut.r_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_count;
    InstrControl = ins(4'hE, 2'b00, 6'b001000, 4'd1);
    ALUFlags = 4'b0000;
    #1;
    check("wrap_ctrl", 32'(Control), 32'h0004);
    @(posedge clk); #1;
    check("wrap_count", InstrCount, 32'd0);
    check("wrap_flags_hold", 32'(Flags), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
